trap_monitor_mc: RTL and testbench
==================================

Name: trap_monitor_mc

Overview:
Multi-core simulation trap/termination monitor, successor to the single-core trap monitor. It tracks per-core trap events and keeps internal cycle and retired-instruction counters. A per-core commit watchdog detects hangs. It resolves a single run verdict (pass/fail code, trapping core, PC) for the testbench top, and supports stop-on-first-trap and wait-for-all-cores modes.

Parameters:
NUM_CORES, 2, number of monitored cores (1..8)
PC_W, 64, trap PC width
CNT_W, 64, cycle/instruction counter width
CMT_W, 3, width of per-core commit count per cycle
TIMEOUT, 5000, cycles without commit on an untrapped core before hang; 0 disables watchdog
STOP_ON_FIRST, 1, 1: first trap ends run; 0: run ends when all cores trapped
HANG_CODE, 32'hFFFF_FFFE, result_code reported on hang

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
trap_valid  in  NUM_CORES  per-core trap strobe (bit i = core i)
trap_code  in  32*NUM_CORES  per-core trap code, core i at [32i+31:32i]
trap_pc  in  PC_W*NUM_CORES  per-core trap PC
commit_num  in  CMT_W*NUM_CORES  instructions retired this cycle per core
done  out  1  run finished (trap or hang), sticky
done_pulse  out  1  one-cycle pulse on entry to a terminal state
hang  out  1  run ended by watchdog, sticky
result_code  out  32  verdict code; 32'hFFFF_FFFF while running
result_core  out  max(1,clog2(NUM_CORES))  core responsible for verdict
result_pc  out  PC_W  trap PC of result_core (0 on hang)
trapped_mask  out  NUM_CORES  cores that have trapped
cycle_cnt  out  CNT_W  cycles spent in RUN
instr_cnt  out  CNT_W*NUM_CORES  per-core retired instruction count

Behaviour:
- States: RUN, DONE, HUNG. Reset → RUN. DONE and HUNG are sticky until reset.
- Reset (async, any time incl. mid-run or in terminal state): state RUN; done=0, done_pulse=0, hang=0, result_code=32'hFFFF_FFFF, result_core=0, result_pc=0, trapped_mask=0, cycle_cnt=0, all instr_cnt=0, internal per-core code/pc records and idle counters=0.
- All outputs are registered; an event at edge k is visible after edge k.
- cycle_cnt: +1 per cycle in RUN, frozen in DONE/HUNG, saturates at all-ones.
- instr_cnt[i]: += commit_num[i] (zero-extended) per RUN cycle while core i not yet trapped. The commit in the trap cycle counts. Saturates at all-ones and does not wrap.
- Trap capture: in RUN, trap_valid[i] with trapped_mask[i]=0 latches trap_code[i]/trap_pc[i] into core record i and sets trapped_mask[i]. Further trap_valid[i] is ignored (first trap wins). Traps in DONE/HUNG are ignored.
- Watchdog (TIMEOUT>0): idle[i] clears on commit_num[i]!=0 or on trap capture, else +1. Only cores with trapped_mask[i]=0 are checked. Timeout fires when idle[i] reaches TIMEOUT-1 and the current cycle has no commit or trap for core i, i.e. exactly TIMEOUT consecutive idle cycles.
- Per-cycle resolution order in RUN: (1) capture traps; (2) evaluate termination using the updated mask; (3) if not terminated, evaluate watchdog.
  - STOP_ON_FIRST=1: any capture → DONE. Result = lowest-index core trapping this cycle.
  - STOP_ON_FIRST=0: mask all-ones → DONE. Result = lowest-index core with nonzero recorded code; if all codes are zero, result = core 0 with code 0.
  - Watchdog → HUNG: hang=1, result_code=HANG_CODE, result_core=lowest-index timed-out core, result_pc=0.
  - A trap and a timeout on the same core in the same cycle: the trap wins and the core is no longer watched.
- Entering DONE/HUNG: done=1, done_pulse=1 for exactly one cycle. result_* is written in the same edge and held thereafter.
- Widths: instr_cnt core i at [CNT_W*i+CNT_W-1:CNT_W*i]. NUM_CORES=1 yields a 1-bit result_core tied to 0.

Test Plan:
- Single trap, NUM_CORES=2, STOP_ON_FIRST=1: commit_num=1 on both cores for 10 cycles, then trap_valid=2'b10, code=0, pc=0x8000_0100 → done=1 and done_pulse=1 one cycle later; result_core=1, result_code=0, result_pc=0x8000_0100, cycle_cnt=11, instr_cnt=11 on each core, counters frozen afterwards.
- Simultaneous traps: trap_valid=2'b11 with codes 5 and 0 → result_core=0, result_code=5, trapped_mask=2'b11.
- Wait-all mode (STOP_ON_FIRST=0): core0 traps code 0 at cycle 3; core1 keeps committing and traps code 7 at cycle 20 → done only after cycle 20, result_core=1, result_code=7; instr_cnt[0] stops at cycle 3.
- Hang: TIMEOUT=16, core1 commit_num=0 from cycle 0 → hang=1, done=1 after exactly 16 cycles; result_code=32'hFFFF_FFFE, result_core=1. Repeat with core1 trapping on cycle 15 → no hang.
- Saturation/wrap: CNT_W=4, commit_num=7 each cycle → instr_cnt saturates at 15 and does not wrap; cycle_cnt saturates at 15.
- Async reset mid-run and in DONE: assert reset between clock edges → all outputs return to reset values immediately, result_code=32'hFFFF_FFFF; after deassertion the monitor runs a fresh trap scenario correctly.

Source files
------------

// File: rtl/trap_monitor_mc.sv
// Multi-core trap/termination monitor: records per-core traps, counts cycles and
// retired instructions, watches for commit hangs and resolves a single run verdict.
module trap_monitor_mc #(
  parameter int          NUM_CORES     = 2,
  parameter int          PC_W          = 64,
  parameter int          CNT_W         = 64,
  parameter int          CMT_W         = 3,
  parameter int          TIMEOUT       = 5000,
  parameter int          STOP_ON_FIRST = 1,
  parameter logic [31:0] HANG_CODE     = 32'hFFFF_FFFE,
  localparam int         CORE_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       trap_valid,
  input  logic [32*NUM_CORES-1:0]    trap_code,
  input  logic [PC_W*NUM_CORES-1:0]  trap_pc,
  input  logic [CMT_W*NUM_CORES-1:0] commit_num,
  output logic                       done,
  output logic                       done_pulse,
  output logic                       hang,
  output logic [31:0]                result_code,
  output logic [CORE_W-1:0]          result_core,
  output logic [PC_W-1:0]            result_pc,
  output logic [NUM_CORES-1:0]       trapped_mask,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W*NUM_CORES-1:0] instr_cnt,
  output logic [1:0]                 state_dbg
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DONE = 2'd1, S_HUNG = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 done_d, pulse_d, hang_d;
  logic [31:0]          rcode_d;
  logic [CORE_W-1:0]    rcore_d;
  logic [PC_W-1:0]      rpc_d;
  logic [NUM_CORES-1:0] mask_d, cap, tmo;
  logic [CNT_W-1:0]     cycle_d;
  logic [31:0]          rec_code_q [NUM_CORES];
  logic [31:0]          rec_code_d [NUM_CORES];
  logic [PC_W-1:0]      rec_pc_q   [NUM_CORES];
  logic [PC_W-1:0]      rec_pc_d   [NUM_CORES];
  logic [IDLE_W-1:0]    idle_q     [NUM_CORES];
  logic [IDLE_W-1:0]    idle_d     [NUM_CORES];
  logic [CNT_W-1:0]     instr_q    [NUM_CORES];
  logic [CNT_W-1:0]     instr_d    [NUM_CORES];
  logic [CMT_W-1:0]     cmt;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    state_d    = state_q;
    done_d     = done;
    pulse_d    = 1'b0;
    hang_d     = hang;
    rcode_d    = result_code;
    rcore_d    = result_core;
    rpc_d      = result_pc;
    mask_d     = trapped_mask;
    cycle_d    = cycle_cnt;
    rec_code_d = rec_code_q;
    rec_pc_d   = rec_pc_q;
    idle_d     = idle_q;
    instr_d    = instr_q;
    cap        = '0;
    tmo        = '0;
    cmt        = '0;
    sum        = '0;
    if (state_q == S_RUN) begin
      if (~&cycle_cnt) cycle_d = cycle_cnt + 1'b1;
      // Capture first, so a trap in the same cycle as a timeout takes precedence.
      for (int i = 0; i < NUM_CORES; i++) begin
        cmt = commit_num[i*CMT_W +: CMT_W];
        if (!trapped_mask[i]) begin
          sum        = {1'b0, instr_q[i]} + SUM_W'(cmt);
          instr_d[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (trap_valid[i]) begin
            cap[i]        = 1'b1;
            rec_code_d[i] = trap_code[i*32 +: 32];
            rec_pc_d[i]   = trap_pc[i*PC_W +: PC_W];
            idle_d[i]     = '0;
          end else if (cmt != '0) begin
            idle_d[i] = '0;
          end else if (TIMEOUT > 0 && idle_q[i] == IDLE_W'(TIMEOUT - 1)) begin
            tmo[i] = 1'b1;
          end else begin
            idle_d[i] = idle_q[i] + 1'b1;
          end
        end
      end
      mask_d = trapped_mask | cap;
      if (STOP_ON_FIRST != 0 && cap != '0) begin
        state_d = S_DONE;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
          if (cap[i]) begin
            rcore_d = CORE_W'(i);
            rcode_d = rec_code_d[i];
            rpc_d   = rec_pc_d[i];
          end
        end
      end else if (STOP_ON_FIRST == 0 && &mask_d) begin
        state_d = S_DONE;
        rcore_d = '0;
        rcode_d = rec_code_d[0];
        rpc_d   = rec_pc_d[0];
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
          if (rec_code_d[i] != 32'd0) begin
            rcore_d = CORE_W'(i);
            rcode_d = rec_code_d[i];
            rpc_d   = rec_pc_d[i];
          end
        end
      end else if (tmo != '0) begin
        state_d = S_HUNG;
        hang_d  = 1'b1;
        rcode_d = HANG_CODE;
        rpc_d   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
          if (tmo[i]) rcore_d = CORE_W'(i);
        end
      end
      if (state_d != S_RUN) begin
        done_d  = 1'b1;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      hang         <= 1'b0;
      result_code  <= 32'hFFFF_FFFF;
      result_core  <= '0;
      result_pc    <= '0;
      trapped_mask <= '0;
      cycle_cnt    <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        rec_code_q[i] <= '0;
        rec_pc_q[i]   <= '0;
        idle_q[i]     <= '0;
        instr_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      done         <= done_d;
      done_pulse   <= pulse_d;
      hang         <= hang_d;
      result_code  <= rcode_d;
      result_core  <= rcore_d;
      result_pc    <= rpc_d;
      trapped_mask <= mask_d;
      cycle_cnt    <= cycle_d;
      rec_code_q   <= rec_code_d;
      rec_pc_q     <= rec_pc_d;
      idle_q       <= idle_d;
      instr_q      <= instr_d;
    end
  end

  always_comb begin
    instr_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) instr_cnt[i*CNT_W +: CNT_W] = instr_q[i];
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_trap_monitor_mc.sv
// Bench for trap_monitor_mc: three configurations share one stimulus stream and are
// compared every cycle against a per-configuration reference model, plus directed checks.
module tb_trap_monitor_mc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   trap_valid;
  logic [63:0]  trap_code;
  logic [127:0] trap_pc;
  logic [5:0]   commit_num;

  always #5 clk = ~clk;

  // a: stop-on-first, TIMEOUT 16; b: wait-all, no watchdog; c: wait-all, 4-bit counters, TIMEOUT 5
  logic a_done, a_pulse, a_hang; logic [31:0] a_code; logic [0:0] a_core; logic [63:0] a_pc;
  logic [1:0] a_mask; logic [63:0] a_cyc; logic [127:0] a_instr; logic [1:0] a_st;
  logic b_done, b_pulse, b_hang; logic [31:0] b_code; logic [0:0] b_core; logic [63:0] b_pc;
  logic [1:0] b_mask; logic [63:0] b_cyc; logic [127:0] b_instr; logic [1:0] b_st;
  logic c_done, c_pulse, c_hang; logic [31:0] c_code; logic [0:0] c_core; logic [63:0] c_pc;
  logic [1:0] c_mask; logic [3:0] c_cyc; logic [7:0] c_instr; logic [1:0] c_st;

  trap_monitor_mc #(.NUM_CORES(2), .PC_W(64), .CNT_W(64), .CMT_W(3), .TIMEOUT(16),
                    .STOP_ON_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .commit_num(commit_num), .done(a_done), .done_pulse(a_pulse),
    .hang(a_hang), .result_code(a_code), .result_core(a_core), .result_pc(a_pc),
    .trapped_mask(a_mask), .cycle_cnt(a_cyc), .instr_cnt(a_instr), .state_dbg(a_st));

  trap_monitor_mc #(.NUM_CORES(2), .PC_W(64), .CNT_W(64), .CMT_W(3), .TIMEOUT(0),
                    .STOP_ON_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .commit_num(commit_num), .done(b_done), .done_pulse(b_pulse),
    .hang(b_hang), .result_code(b_code), .result_core(b_core), .result_pc(b_pc),
    .trapped_mask(b_mask), .cycle_cnt(b_cyc), .instr_cnt(b_instr), .state_dbg(b_st));

  trap_monitor_mc #(.NUM_CORES(2), .PC_W(64), .CNT_W(4), .CMT_W(3), .TIMEOUT(5),
                    .STOP_ON_FIRST(0), .HANG_CODE(32'h0BAD_0BAD)) dut_c (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .commit_num(commit_num), .done(c_done), .done_pulse(c_pulse),
    .hang(c_hang), .result_code(c_code), .result_core(c_core), .result_pc(c_pc),
    .trapped_mask(c_mask), .cycle_cnt(c_cyc), .instr_cnt(c_instr), .state_dbg(c_st));

  // Reference model: one entry per configuration
  int          m_to   [3] = '{16, 0, 5};
  bit          m_sof  [3] = '{1'b1, 1'b0, 1'b0};
  logic [63:0] m_cmax [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd15};
  logic [31:0] m_hcode[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0BAD_0BAD};
  bit          m_running[3], m_done[3], m_pulse[3], m_hang[3];
  logic [31:0] m_rcode[3];
  int          m_rcore[3];
  logic [63:0] m_rpc[3], m_cyc[3];
  logic [1:0]  m_mask[3];
  logic [63:0] m_instr[3][2], m_pc[3][2];
  logic [31:0] m_code[3][2];
  int          m_idle[3][2];

  logic [32:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_running[k] = 1'b1; m_done[k] = 1'b0; m_pulse[k] = 1'b0; m_hang[k] = 1'b0;
      m_rcode[k] = 32'hFFFF_FFFF; m_rcore[k] = 0; m_rpc[k] = '0; m_cyc[k] = '0; m_mask[k] = '0;
      for (int i = 0; i < 2; i++) begin
        m_instr[k][i] = '0; m_pc[k][i] = '0; m_code[k][i] = '0; m_idle[k][i] = 0;
      end
    end
    exp_q.delete();
  endtask

  task automatic model_finish(input int k, input int core, input logic [31:0] code,
                              input logic [63:0] pc, input bit hung);
    m_running[k] = 1'b0; m_done[k] = 1'b1; m_pulse[k] = 1'b1; m_hang[k] = hung;
    m_rcore[k] = core; m_rcode[k] = code; m_rpc[k] = pc;
  endtask

  task automatic model_step();
    logic [2:0] cmt;
    int first_cap, first_to, pick;
    for (int k = 0; k < 3; k++) begin
      m_pulse[k] = 1'b0;
      if (m_running[k]) begin
        if (m_cyc[k] != m_cmax[k]) m_cyc[k] = m_cyc[k] + 1;
        first_cap = -1; first_to = -1;
        for (int i = 0; i < 2; i++) begin
          cmt = commit_num[3*i +: 3];
          if (!m_mask[k][i]) begin
            if (m_cmax[k] - m_instr[k][i] < 64'(cmt)) m_instr[k][i] = m_cmax[k];
            else m_instr[k][i] = m_instr[k][i] + 64'(cmt);
            if (trap_valid[i]) begin
              m_code[k][i] = trap_code[32*i +: 32];
              m_pc[k][i]   = trap_pc[64*i +: 64];
              m_mask[k][i] = 1'b1;
              m_idle[k][i] = 0;
              if (first_cap < 0) first_cap = i;
            end else if (cmt != 0) m_idle[k][i] = 0;
            else m_idle[k][i]++;
            if (!m_mask[k][i] && m_to[k] > 0 && m_idle[k][i] >= m_to[k] && first_to < 0)
              first_to = i;
          end
        end
        if (m_sof[k] && first_cap >= 0) begin
          model_finish(k, first_cap, m_code[k][first_cap], m_pc[k][first_cap], 1'b0);
        end else if (!m_sof[k] && m_mask[k] == 2'b11) begin
          pick = (m_code[k][0] != 0) ? 0 : (m_code[k][1] != 0) ? 1 : 0;
          model_finish(k, pick, m_code[k][pick], m_pc[k][pick], 1'b0);
        end else if (first_to >= 0) begin
          model_finish(k, first_to, m_hcode[k], 64'd0, 1'b1);
        end
      end
    end
    if (m_pulse[0]) exp_q.push_back({1'(m_rcore[0]), m_rcode[0]});
  endtask

  task automatic check_dut(input string nm, input int k, input logic done, input logic pulse,
                           input logic hng, input logic [31:0] code, input logic [63:0] core,
                           input logic [63:0] pc, input logic [1:0] mask, input logic [63:0] cyc,
                           input logic [63:0] i0, input logic [63:0] i1);
    check({nm, "_done"},  64'(done),  64'(m_done[k]));
    check({nm, "_pulse"}, 64'(pulse), 64'(m_pulse[k]));
    check({nm, "_hang"},  64'(hng),   64'(m_hang[k]));
    check({nm, "_code"},  64'(code),  64'(m_rcode[k]));
    check({nm, "_core"},  core,       64'(m_rcore[k]));
    check({nm, "_pc"},    pc,         m_rpc[k]);
    check({nm, "_mask"},  64'(mask),  64'(m_mask[k]));
    check({nm, "_cyc"},   cyc,        m_cyc[k]);
    check({nm, "_instr0"}, i0,        m_instr[k][0]);
    check({nm, "_instr1"}, i1,        m_instr[k][1]);
  endtask

  task automatic compare();
    check_dut("a", 0, a_done, a_pulse, a_hang, a_code, 64'(a_core), a_pc, a_mask, a_cyc,
              a_instr[63:0], a_instr[127:64]);
    check_dut("b", 1, b_done, b_pulse, b_hang, b_code, 64'(b_core), b_pc, b_mask, b_cyc,
              b_instr[63:0], b_instr[127:64]);
    check_dut("c", 2, c_done, c_pulse, c_hang, c_code, 64'(c_core), c_pc, c_mask, 64'(c_cyc),
              64'(c_instr[3:0]), 64'(c_instr[7:4]));
    if (a_pulse) begin
      if (exp_q.size() == 0) check("sb_spurious_pulse", 64'(a_pulse), 64'd0);
      else check("sb_verdict", 64'({a_core, a_code}), 64'(exp_q.pop_front()));
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    trap_valid = '0; trap_code = '0; trap_pc = '0; commit_num = '0;
  endtask

  task automatic set_core(input int i, input bit tv, input logic [31:0] code,
                          input logic [63:0] pc, input logic [2:0] cmt);
    trap_valid[i]         = tv;
    trap_code[32*i +: 32] = code;
    trap_pc[64*i +: 64]   = pc;
    commit_num[3*i +: 3]  = cmt;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // Reset asserted between edges; outputs must clear before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    compare();
    check("rst_code", 64'(a_code), 64'hFFFF_FFFF);
    check("rst_done", 64'(a_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int quiet;
    clear_inputs();
    model_reset();
    do_reset();

    // Single trap on core 1 after 10 committing cycles
    for (int cyc = 0; cyc < 10; cyc++) begin
      set_core(0, 1'b0, 32'd0, 64'd0, 3'd1);
      set_core(1, 1'b0, 32'd0, 64'd0, 3'd1);
      step();
    end
    set_core(1, 1'b1, 32'd0, 64'h8000_0100, 3'd1);
    step();
    check("s1_done", 64'(a_done), 64'd1);
    check("s1_pulse", 64'(a_pulse), 64'd1);
    check("s1_core", 64'(a_core), 64'd1);
    check("s1_code", 64'(a_code), 64'd0);
    check("s1_pc", a_pc, 64'h8000_0100);
    check("s1_cyc", a_cyc, 64'd11);
    check("s1_instr0", a_instr[63:0], 64'd11);
    check("s1_instr1", a_instr[127:64], 64'd11);
    set_core(1, 1'b0, 32'd0, 64'd0, 3'd1);
    for (int cyc = 0; cyc < 3; cyc++) step();
    check("s1_frozen_cyc", a_cyc, 64'd11);
    check("s1_frozen_instr", a_instr[63:0], 64'd11);
    check("s1_pulse_once", 64'(a_pulse), 64'd0);
    do_reset();

    // Simultaneous traps
    set_core(0, 1'b1, 32'd5, 64'h100, 3'd0);
    set_core(1, 1'b1, 32'd0, 64'h200, 3'd0);
    step();
    check("sim_core", 64'(a_core), 64'd0);
    check("sim_code", 64'(a_code), 64'd5);
    check("sim_mask", 64'(a_mask), 64'd3);
    check("sim_b_done", 64'(b_done), 64'd1);
    check("sim_b_code", 64'(b_code), 64'd5);
    do_reset();

    // Wait-all: core 0 traps code 0 at cycle 3, core 1 traps code 7 at cycle 20
    for (int cyc = 0; cyc <= 20; cyc++) begin
      set_core(0, cyc == 3, 32'd0, 64'h30, 3'd1);
      set_core(1, cyc == 20, 32'd7, 64'h4000, 3'd1);
      step();
      if (cyc == 19) check("wa_not_done", 64'(b_done), 64'd0);
    end
    check("wa_done", 64'(b_done), 64'd1);
    check("wa_core", 64'(b_core), 64'd1);
    check("wa_code", 64'(b_code), 64'd7);
    check("wa_pc", b_pc, 64'h4000);
    check("wa_instr0", b_instr[63:0], 64'd4);
    check("wa_instr1", b_instr[127:64], 64'd21);
    do_reset();

    // Hang: core 1 never commits
    for (int cyc = 0; cyc < 16; cyc++) begin
      set_core(0, 1'b0, 32'd0, 64'd0, 3'd1);
      set_core(1, 1'b0, 32'd0, 64'd0, 3'd0);
      step();
      if (cyc == 14) check("hang_early", 64'(a_hang), 64'd0);
    end
    check("hang_hang", 64'(a_hang), 64'd1);
    check("hang_done", 64'(a_done), 64'd1);
    check("hang_code", 64'(a_code), 64'hFFFF_FFFE);
    check("hang_core", 64'(a_core), 64'd1);
    check("hang_pc", a_pc, 64'd0);
    check("hang_c_code", 64'(c_code), 64'h0BAD_0BAD);
    check("hang_c_core", 64'(c_core), 64'd1);
    do_reset();

    // Same, but core 1 traps on the cycle the watchdog would fire
    for (int cyc = 0; cyc < 16; cyc++) begin
      set_core(0, 1'b0, 32'd0, 64'd0, 3'd1);
      set_core(1, cyc == 15, 32'd3, 64'h77, 3'd0);
      step();
    end
    check("hang_trap_wins_hang", 64'(a_hang), 64'd0);
    check("hang_trap_wins_code", 64'(a_code), 64'd3);
    check("hang_trap_wins_core", 64'(a_core), 64'd1);
    do_reset();

    // Saturation of narrow counters
    for (int cyc = 0; cyc < 20; cyc++) begin
      set_core(0, 1'b0, 32'd0, 64'd0, 3'd7);
      set_core(1, 1'b0, 32'd0, 64'd0, 3'd7);
      step();
    end
    check("sat_instr0", 64'(c_instr[3:0]), 64'd15);
    check("sat_instr1", 64'(c_instr[7:4]), 64'd15);
    check("sat_cyc", 64'(c_cyc), 64'd15);
    check("sat_wide_instr", a_instr[63:0], 64'd140);

    // Randomized segments, with occasional mid-run resets
    for (int seg = 0; seg < 30; seg++) begin
      do_reset();
      quiet = $urandom_range(0, 2);
      for (int cyc = 0; cyc < $urandom_range(40, 80); cyc++) begin
        for (int i = 0; i < 2; i++) begin
          logic [31:0] code;
          case ($urandom_range(0, 3))
            0: code = 32'd0;
            1: code = 32'd1;
            2: code = 32'd5;
            default: code = $urandom;
          endcase
          set_core(i, $urandom_range(0, 24) == 0, code, {$urandom, $urandom},
                   (i == quiet || $urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7)));
        end
        step();
        if ($urandom_range(0, 59) == 0) do_reset();
      end
    end

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
